// File: rtl/fetch_unit.sv
// Instruction-fetch front end: walks the program counter through the TLB, folds
// two-word MVI into instruction+immediate and hands it off over valid/ready.
module fetch_unit #(
    parameter int          ADDR_W   = 6,
    parameter int          PROG_LEN = 38,
    parameter logic [3:0]  MVI_OP   = 4'b0001
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [ADDR_W-1:0] tlb_addr,
    input  logic [15:0]       tlb_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr,
    output logic [3:0]        op,
    output logic [2:0]        rx,
    output logic [2:0]        ry,
    output logic              has_imm,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              done
);

    // state | meaning
    // FETCH | read word at pc; end of program if pc >= PROG_LEN
    // IMM   | read MVI immediate at pc
    // HOLD  | instruction presented, waiting for handshake
    // DONE  | program exhausted, sticky until Reset
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_IMM   = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One extra bit so a PROG_LEN of 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] PROG_END = (ADDR_W+1)'(PROG_LEN);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       instr_q;
    logic [15:0]       imm_q;
    logic              valid_q;
    logic              done_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if ({1'b0, pc_q} >= PROG_END) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        instr_q <= tlb_data;
                        pc_q    <= pc_q + 1'b1;
                        if (tlb_data[9:6] == MVI_OP) begin
                            state_q <= S_IMM;
                        end else begin
                            imm_q   <= '0;
                            state_q <= S_HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_IMM: begin
                    // A trailing MVI reads past the program; the TLB miss yields 0.
                    imm_q   <= tlb_data;
                    pc_q    <= pc_q + 1'b1;
                    state_q <= S_HOLD;
                    valid_q <= 1'b1;
                end
                S_HOLD: begin
                    if (valid_q && instr_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                        if (branch_en) begin
                            pc_q <= branch_target;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
            endcase
        end
    end

    assign tlb_addr    = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign imm         = imm_q;
    assign instr_valid = valid_q;
    assign done        = done_q;
    assign op          = instr_q[9:6];
    assign rx          = instr_q[12:10];
    assign ry          = instr_q[15:13];
    assign has_imm     = (instr_q[9:6] == MVI_OP);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, MVI fold, backpressure, branch,
// end-of-program with trailing MVI, and reset during an MVI.
module tb_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  tlb_addr;
    logic [15:0] tlb_data;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [3:0]  op;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic        has_imm;
    logic [15:0] imm;
    logic [5:0]  pc;
    logic        branch_en = 1'b0;
    logic [5:0]  branch_target = 6'd0;
    logic        done;

    logic [15:0] mem [0:63];

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.ADDR_W(6), .PROG_LEN(5), .MVI_OP(4'b0001)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .tlb_addr      (tlb_addr),
        .tlb_data      (tlb_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .op            (op),
        .rx            (rx),
        .ry            (ry),
        .has_imm       (has_imm),
        .imm           (imm),
        .pc            (pc),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .done          (done)
    );

    always #5 Clock = ~Clock;

    // TLB model: words beyond the program miss and read as 0
    always_comb tlb_data = (tlb_addr < 6'd5) ? mem[tlb_addr] : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"},   32'(instr_valid), 32'd0);
        chk({tag, ".done"},    32'(done),        32'd0);
        chk({tag, ".addr"},    32'(tlb_addr),    32'd0);
        chk({tag, ".pc"},      32'(pc),          32'd0);
        chk({tag, ".instr"},   32'(instr),       32'd0);
        chk({tag, ".imm"},     32'(imm),         32'd0);
        chk({tag, ".op"},      32'(op),          32'd0);
        chk({tag, ".rx"},      32'(rx),          32'd0);
        chk({tag, ".ry"},      32'(ry),          32'd0);
        chk({tag, ".has_imm"}, 32'(has_imm),     32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0040;
        mem[1] = 16'h0002;
        mem[2] = 16'h0440;
        mem[3] = 16'h0003;
        mem[4] = 16'h0580;

        // reset values
        tick();
        chk_zero("rst1");
        tick();
        chk_zero("rst2");
        Reset = 1'b0;
        chk("rel.addr", 32'(tlb_addr), 32'd0);
        instr_ready = 1'b1;

        // MVI fold
        tick();
        chk("mvi0.imm_state.valid", 32'(instr_valid), 32'd0);
        chk("mvi0.imm_state.addr",  32'(tlb_addr),    32'd1);
        tick();
        chk("mvi0.valid",   32'(instr_valid), 32'd1);
        chk("mvi0.instr",   32'(instr),       32'h0040);
        chk("mvi0.op",      32'(op),          32'd1);
        chk("mvi0.rx",      32'(rx),          32'd0);
        chk("mvi0.has_imm", 32'(has_imm),     32'd1);
        chk("mvi0.imm",     32'(imm),         32'h0002);
        chk("mvi0.pc",      32'(pc),          32'd2);
        tick();
        chk("gap1a.valid", 32'(instr_valid), 32'd0);
        tick();
        chk("gap1b.valid", 32'(instr_valid), 32'd0);
        tick();
        chk("mvi1.valid",   32'(instr_valid), 32'd1);
        chk("mvi1.op",      32'(op),          32'd1);
        chk("mvi1.rx",      32'(rx),          32'd1);
        chk("mvi1.has_imm", 32'(has_imm),     32'd1);
        chk("mvi1.imm",     32'(imm),         32'h0003);
        tick();
        chk("gap2.valid", 32'(instr_valid), 32'd0);
        tick();
        chk("w4.valid",   32'(instr_valid), 32'd1);
        chk("w4.instr",   32'(instr),       32'h0580);
        chk("w4.op",      32'(op),          32'd6);
        chk("w4.rx",      32'(rx),          32'd1);
        chk("w4.ry",      32'(ry),          32'd0);
        chk("w4.has_imm", 32'(has_imm),     32'd0);
        chk("w4.imm",     32'(imm),         32'd0);
        chk("w4.pc",      32'(pc),          32'd5);

        // branch back to 3 on the handshake of the word at address 4
        branch_en     = 1'b1;
        branch_target = 6'd3;
        tick();
        chk("br.valid", 32'(instr_valid), 32'd0);
        chk("br.addr",  32'(tlb_addr),    32'd3);
        branch_en = 1'b0;
        tick();
        chk("br.tgt.valid", 32'(instr_valid), 32'd1);
        chk("br.tgt.instr", 32'(instr),       32'h0003);
        chk("br.tgt.pc",    32'(pc),          32'd4);

        // backpressure: everything held while ready is low
        instr_ready = 1'b0;
        branch_en   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.valid", 32'(instr_valid), 32'd1);
            chk("bp.instr", 32'(instr),       32'h0003);
            chk("bp.imm",   32'(imm),         32'd0);
            chk("bp.op",    32'(op),          32'd0);
            chk("bp.pc",    32'(pc),          32'd4);
            chk("bp.done",  32'(done),        32'd0);
        end
        branch_en   = 1'b0;
        instr_ready = 1'b1;
        tick();
        chk("bp.rel1.valid", 32'(instr_valid), 32'd0);
        chk("bp.rel1.addr",  32'(tlb_addr),    32'd4);
        tick();
        chk("bp.rel2.valid", 32'(instr_valid), 32'd1);
        chk("bp.rel2.instr", 32'(instr),       32'h0580);
        tick();
        chk("end.fetch.done",  32'(done),        32'd0);
        chk("end.fetch.valid", 32'(instr_valid), 32'd0);
        chk("end.fetch.addr",  32'(tlb_addr),    32'd5);
        tick();
        chk("end.done",  32'(done),        32'd1);
        chk("end.valid", 32'(instr_valid), 32'd0);

        // trailing MVI at the last program word
        Reset = 1'b1;
        mem[4] = 16'h0040;
        tick();
        chk("rst3.done",  32'(done),        32'd0);
        chk("rst3.valid", 32'(instr_valid), 32'd0);
        Reset         = 1'b0;
        branch_en     = 1'b1;
        branch_target = 6'd4;
        tick();
        tick();
        chk("tail.first.valid", 32'(instr_valid), 32'd1);
        tick();
        chk("tail.br.addr", 32'(tlb_addr), 32'd4);
        branch_en = 1'b0;
        tick();
        chk("tail.imm_state.addr",  32'(tlb_addr),    32'd5);
        chk("tail.imm_state.valid", 32'(instr_valid), 32'd0);
        tick();
        chk("tail.valid",   32'(instr_valid), 32'd1);
        chk("tail.instr",   32'(instr),       32'h0040);
        chk("tail.has_imm", 32'(has_imm),     32'd1);
        chk("tail.imm",     32'(imm),         32'd0);
        chk("tail.pc",      32'(pc),          32'd6);
        tick();
        chk("tail.fetch.done", 32'(done), 32'd0);
        tick();
        chk("tail.done",       32'(done),        32'd1);
        chk("tail.done.valid", 32'(instr_valid), 32'd0);
        branch_target = 6'd0;
        for (int i = 0; i < 10; i++) begin
            instr_ready = i[0];
            branch_en   = ~i[0];
            tick();
            chk("sticky.done",  32'(done),        32'd1);
            chk("sticky.valid", 32'(instr_valid), 32'd0);
            chk("sticky.addr",  32'(tlb_addr),    32'd6);
        end

        // reset pulse while in IMM aborts the MVI
        branch_en   = 1'b0;
        instr_ready = 1'b1;
        Reset       = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        chk("mid.imm.addr",  32'(tlb_addr),    32'd1);
        chk("mid.imm.valid", 32'(instr_valid), 32'd0);
        Reset = 1'b1;
        tick();
        chk("mid.rst.valid", 32'(instr_valid), 32'd0);
        chk("mid.rst.addr",  32'(tlb_addr),    32'd0);
        chk("mid.rst.done",  32'(done),        32'd0);
        Reset = 1'b0;
        tick();
        chk("mid.refetch.valid", 32'(instr_valid), 32'd0);
        chk("mid.refetch.addr",  32'(tlb_addr),    32'd1);
        tick();
        chk("mid.reissue.valid", 32'(instr_valid), 32'd1);
        chk("mid.reissue.imm",   32'(imm),         32'h0002);

        // reset wins over a simultaneous handshake with branch
        branch_en     = 1'b1;
        branch_target = 6'd3;
        Reset         = 1'b1;
        tick();
        chk("prio.valid", 32'(instr_valid), 32'd0);
        chk("prio.pc",    32'(pc),          32'd0);
        chk("prio.instr", 32'(instr),       32'd0);
        Reset     = 1'b0;
        branch_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
